pp_out_collect_ctrl: RTL and testbench
======================================

Name: pp_out_collect_ctrl

Overview:
- Output-side ping-pong buffer and controller for the multi-head attention datapath.
- Accepts one accumulated result block per pulse from the systolic/accumulator wrapper and stores a full output row (COL_Y blocks) into bank 0 or bank 1.
- Drains completed banks to a downstream valid/ready stream.
- While one bank is being written from the matmul, the other is read out. This is the drain counterpart of the input-side ping-pong controller.

Parameters:
- DATA_WIDTH, 64, width of one result block (BLOCK_SIZE×BLOCK_SIZE packed words).
- COL_Y, 4, blocks per output row = entries per bank; must be ≥2.
- MAX_ROWS, 16, rows drained before entering DONE; must be ≥1.
- ADDR_WIDTH, $clog2(COL_Y), bank address width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; arms the block from IDLE.
- in_valid  in  1  result block present (driven from the accumulator-done strobe).
- in_data  in  DATA_WIDTH  result block.
- in_ready  out  1  write bank has space and block is in RUN.
- out_valid  out  1  out_data valid.
- out_data  out  DATA_WIDTH  drained block.
- out_last  out  1  last block of a row, qualified by out_valid.
- out_ready  in  1  downstream accepts.
- wr_bank  out  1  bank currently being written.
- rd_bank  out  1  bank currently being read.
- overflow_err  out  1  sticky; in_valid seen while in_ready=0 in RUN.
- done  out  1  level; MAX_ROWS rows drained.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: all outputs 0, state=IDLE, wr_sel=rd_sel=0, wr_addr=rd_addr=0, bank_full=2'b00, row_cnt=0. Memory contents need not be cleared.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge; any partial row is discarded.
- States:
  - IDLE → RUN on start.
  - RUN → DONE when the out_last handshake completes with row_cnt==MAX_ROWS-1.
  - DONE is held until reset.
  - start is ignored outside IDLE.
- in_ready = (state==RUN) & ~bank_full[wr_sel]. This is combinational from registers, never from in_valid.
- Write, on in_valid&in_ready:
  - mem[wr_sel][wr_addr] <= in_data.
  - If wr_addr==COL_Y-1: bank_full[wr_sel]<=1, wr_sel toggles, wr_addr<=0.
  - Otherwise wr_addr increments.
- Read load condition: bank_full[rd_sel] & (~out_valid | out_ready) & state==RUN. On load:
  - out_data <= mem[rd_sel][rd_addr], out_valid<=1, out_last <= (rd_addr==COL_Y-1).
  - If rd_addr==COL_Y-1: bank_full[rd_sel]<=0, rd_sel toggles, rd_addr<=0.
  - Otherwise rd_addr increments.
- When there is no load and out_ready=1: out_valid<=0, out_last<=0.
- While out_valid & ~out_ready, out_data and out_last hold stable.
- row_cnt increments on each handshake with out_last=1.
- done=1 from the cycle after the final handshake; in_ready=0 in DONE.
- Latency: if the final write handshake of a row occurs in cycle N, out_valid=1 in cycle N+2.
- Throughput: with out_ready=1, one block per cycle, including bank→bank crossover with no bubble when the next bank is already full.
- Simultaneous write-completion and read-completion in the same cycle: these always target different banks (set requires not-full, clear requires full). Both updates apply.
- Both banks full: in_ready=0 until the first read load of the rd_sel bank frees it. in_ready returns high in the cycle after that bank's last load.
- overflow_err: set when in_valid=1 & in_ready=0 & state==RUN. Cleared only by reset. The offered block is dropped, and no pointer moves.
- in_valid in IDLE or DONE: ignored, no error flagged.
- wr_bank=wr_sel; rd_bank=rd_sel.

Test Plan:
- Single row, COL_Y=4:
  - Stimulus: start; in_data 0x1,0x2,0x3,0x4 in cycles 2–5; out_ready=1.
  - Required: out_data 0x1..0x4 in cycles 7–10; out_last only with 0x4; rd_bank 0→1 after cycle 10.
- Backpressure and overflow:
  - Stimulus: out_ready=0; write 8 blocks (0x10..0x17).
  - Required: in_ready=0 after the 8th write; out_valid=1 with out_data=0x10 held.
  - Stimulus: a 9th in_valid.
  - Required: overflow_err=1; pointers unchanged.
  - Stimulus: release out_ready.
  - Required: 0x10..0x17 drained in order; in_ready=1 the cycle after 0x13 loads.
- Stalled drain:
  - Stimulus: out_ready toggled 1,0,1,0 during a row of 0xA..0xD.
  - Required: each value appears exactly once, in order; out_data is stable during every stall.
- Streaming to done, MAX_ROWS=3:
  - Stimulus: one in_valid per cycle continuously; out_ready=1.
  - Required: 12 blocks out with no bubbles between rows after the first; done=1 the cycle after the 3rd out_last; in_ready=0 afterwards.
- Async reset mid-row:
  - Stimulus: after 2 of 4 writes, drop rst_n between clock edges.
  - Required: out_valid, in_ready, and bank_full clear immediately; after release and start, a fresh row drains correctly starting from bank 0.
- Start and idle inputs:
  - Stimulus: start pulsed during RUN.
  - Required: no state change.
  - Stimulus: in_valid in IDLE.
  - Required: no write, overflow_err stays 0.

Source files
------------

// File: rtl/pp_out_collect_ctrl.sv
// Output-side ping-pong collector: gathers COL_Y result blocks per row into one of
// two banks while the other bank drains to a valid/ready stream.
module pp_out_collect_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int COL_Y      = 4,
    parameter int MAX_ROWS   = 16,
    parameter int ADDR_WIDTH = $clog2(COL_Y)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic                  overflow_err,
    output logic                  done
);

    localparam int RW = $clog2(MAX_ROWS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic                  wr_sel;
    logic                  rd_sel;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]            bank_full;
    logic [1:0]            bank_full_next;
    logic [RW-1:0]         row_cnt;
    logic [DATA_WIDTH-1:0] mem [2][COL_Y];

    logic running;
    logic wr_fire;
    logic wr_wrap;
    logic rd_load;
    logic rd_wrap;
    logic last_hs;
    logic final_hs;

    assign running  = (state == RUN);
    assign in_ready = running & ~bank_full[wr_sel];
    assign wr_fire  = in_valid & in_ready;
    assign wr_wrap  = (wr_addr == ADDR_WIDTH'(COL_Y - 1));
    assign rd_load  = running & bank_full[rd_sel] & (~out_valid | out_ready);
    assign rd_wrap  = (rd_addr == ADDR_WIDTH'(COL_Y - 1));
    assign last_hs  = out_valid & out_ready & out_last;
    assign final_hs = last_hs & (row_cnt == RW'(MAX_ROWS - 1));

    assign wr_bank = wr_sel;
    assign rd_bank = rd_sel;
    assign done    = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (final_hs) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Set and clear always hit opposite banks, so both may apply in one cycle.
    always_comb begin
        bank_full_next = bank_full;
        if (wr_fire && wr_wrap) bank_full_next[wr_sel] = 1'b1;
        if (rd_load && rd_wrap) bank_full_next[rd_sel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_sel][wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel    <= 1'b0;
            wr_addr   <= '0;
            bank_full <= 2'b00;
        end else begin
            bank_full <= bank_full_next;
            if (wr_fire) begin
                if (wr_wrap) begin
                    wr_sel  <= ~wr_sel;
                    wr_addr <= '0;
                end else begin
                    wr_addr <= wr_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Output register refills on the same edge it is consumed, giving one block per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel    <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (rd_load) begin
                out_data  <= mem[rd_sel][rd_addr];
                out_valid <= 1'b1;
                out_last  <= rd_wrap;
                if (rd_wrap) begin
                    rd_sel  <= ~rd_sel;
                    rd_addr <= '0;
                end else begin
                    rd_addr <= rd_addr + ADDR_WIDTH'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt      <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (last_hs) begin
                row_cnt <= row_cnt + RW'(1);
            end
            if (running && in_valid && !in_ready) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pp_out_collect_ctrl.sv
// Directed bench for pp_out_collect_ctrl: single row, backpressure/overflow, stalled
// drain, streaming to done, async reset mid-row and ignored idle inputs.
module tb_pp_out_collect_ctrl;

    localparam int DW   = 64;
    localparam int COLY = 4;
    localparam int MAXR = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          wr_bank;
    logic          rd_bank;
    logic          overflow_err;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    pp_out_collect_ctrl #(
        .DATA_WIDTH(DW),
        .COL_Y(COLY),
        .MAX_ROWS(MAXR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_last(out_last),
        .out_ready(out_ready),
        .wr_bank(wr_bank),
        .rd_bank(rd_bank),
        .overflow_err(overflow_err),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWord(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic [DW-1:0] d, input logic l);
        checkBit({tag, ".valid"}, out_valid, v);
        if (v) checkWord({tag, ".data"}, out_data, d);
        checkBit({tag, ".last"}, out_last, l);
    endtask

    task automatic applyStimulus(input logic s, input logic iv, input logic [DW-1:0] d, input logic ordy);
        start     = s;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        doReset();
        $display("[TB] reset state");
        checkOutput("rst", 1'b0, '0, 1'b0);
        checkWord("rst.data", out_data, '0);
        checkBit("rst.in_ready", in_ready, 1'b0);
        checkBit("rst.wr_bank", wr_bank, 1'b0);
        checkBit("rst.rd_bank", rd_bank, 1'b0);
        checkBit("rst.overflow", overflow_err, 1'b0);
        checkBit("rst.done", done, 1'b0);

        $display("[TB] in_valid in IDLE is ignored");
        applyStimulus(1'b0, 1'b1, DW'('hDEAD), 1'b1);
        tick();
        tick();
        checkBit("idle.overflow", overflow_err, 1'b0);
        checkBit("idle.in_ready", in_ready, 1'b0);
        checkBit("idle.wr_bank", wr_bank, 1'b0);

        $display("[TB] single row, start pulsed during RUN");
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        tick();
        checkBit("t1.in_ready", in_ready, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(i == 2, 1'b1, DW'(i), 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkBit("t1.wr_bank", wr_bank, 1'b1);
        checkBit("t1.rd_bank0", rd_bank, 1'b0);
        checkBit("t1.in_ready_after", in_ready, 1'b1);
        checkBit("t1.out_valid_lat", out_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("t1.blk%0d", i), 1'b1, DW'(i + 1), i == 3);
        end
        checkBit("t1.rd_bank1", rd_bank, 1'b1);
        tick();
        checkOutput("t1.end", 1'b0, '0, 1'b0);
        checkBit("t1.done", done, 1'b0);

        $display("[TB] backpressure and overflow");
        doReset();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, DW'('h10 + i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkBit("t2.in_ready_full", in_ready, 1'b0);
        checkOutput("t2.held", 1'b1, DW'('h10), 1'b0);
        checkBit("t2.overflow_pre", overflow_err, 1'b0);
        applyStimulus(1'b0, 1'b1, DW'('h99), 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkBit("t2.overflow", overflow_err, 1'b1);
        checkBit("t2.wr_bank", wr_bank, 1'b0);
        checkBit("t2.rd_bank", rd_bank, 1'b0);
        checkWord("t2.wr_addr", DW'(dut.wr_addr), '0);
        checkOutput("t2.held2", 1'b1, DW'('h10), 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            checkOutput($sformatf("t2.blk%0d", i), 1'b1, DW'('h10 + i), (i % 4) == 3);
            if (i == 2) checkBit("t2.in_ready_before", in_ready, 1'b0);
            if (i == 3) checkBit("t2.in_ready_freed", in_ready, 1'b1);
        end
        tick();
        checkOutput("t2.end", 1'b0, '0, 1'b0);
        checkBit("t2.overflow_sticky", overflow_err, 1'b1);

        $display("[TB] stalled drain");
        doReset();
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, DW'('hA + i), 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        tick();
        checkOutput("t3.first", 1'b1, DW'('hA), 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, '0, (i % 2) == 1);
            tick();
            checkOutput($sformatf("t3.step%0d", i), i < 7, DW'('hA + (i + 1) / 2), (i < 7) && ((i + 1) / 2 == 3));
        end

        $display("[TB] streaming to done");
        doReset();
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        tick();
        for (int k = 1; k <= 17; k++) begin
            if (k <= 12) begin
                applyStimulus(1'b0, 1'b1, DW'('h100 + k - 1), 1'b1);
                checkBit($sformatf("t4.in_ready%0d", k), in_ready, 1'b1);
            end else begin
                applyStimulus(1'b0, 1'b0, '0, 1'b1);
            end
            tick();
            checkOutput($sformatf("t4.edge%0d", k), (k >= 5) && (k <= 16), DW'('h100 + k - 5),
                        (k >= 5) && (k <= 16) && (((k - 5) % 4) == 3));
            checkBit($sformatf("t4.done%0d", k), done, k == 17);
        end
        checkBit("t4.in_ready_done", in_ready, 1'b0);
        applyStimulus(1'b1, 1'b1, DW'('h77), 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkBit("t4.done_hold", done, 1'b1);
        checkBit("t4.in_ready_hold", in_ready, 1'b0);
        checkBit("t4.overflow_done", overflow_err, 1'b0);
        checkBit("t4.out_valid_done", out_valid, 1'b0);

        $display("[TB] async reset mid-row");
        doReset();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, DW'('h20 + i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("t5.pre", 1'b1, DW'('h20), 1'b0);
        checkBit("t5.wr_bank_pre", wr_bank, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkBit("t5.out_valid", out_valid, 1'b0);
        checkWord("t5.out_data", out_data, '0);
        checkBit("t5.in_ready", in_ready, 1'b0);
        checkBit("t5.wr_bank", wr_bank, 1'b0);
        checkBit("t5.rd_bank", rd_bank, 1'b0);
        checkWord("t5.bank_full", DW'(dut.bank_full), '0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, DW'('h31 + i), 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkBit("t5.rd_bank_fresh", rd_bank, 1'b0);
        checkBit("t5.wr_bank_fresh", wr_bank, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("t5.blk%0d", i), 1'b1, DW'('h31 + i), i == 3);
        end
        tick();
        checkOutput("t5.end", 1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
